// File: rtl/drc_dsc_frm_arbiter.sv
// Frame-granular round-robin arbiter that shares one downscaler between two pixel
// channels and generates frame-last from its own pixel count so block counters stay aligned.
module drc_dsc_frm_arbiter #(
  parameter int I_PXL_W = 8,
  parameter int COL_NUM = 640,
  parameter int ROW_NUM = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [I_PXL_W-1:0] ch0_pxl_data_i,
  input  logic               ch0_pxl_last_i,
  input  logic               ch0_pxl_vld_i,
  output logic               ch0_pxl_rdy_o,
  input  logic [I_PXL_W-1:0] ch1_pxl_data_i,
  input  logic               ch1_pxl_last_i,
  input  logic               ch1_pxl_vld_i,
  output logic               ch1_pxl_rdy_o,
  output logic [I_PXL_W-1:0] dsc_pxl_data_o,
  output logic               dsc_pxl_last_o,
  output logic               dsc_pxl_vld_o,
  input  logic               dsc_pxl_rdy_i,
  input  logic               dsc_out_last_i,
  input  logic               dsc_out_vld_i,
  input  logic               dsc_out_rdy_i,
  output logic               fwd_ch_id_o,
  output logic               busy_o,
  output logic               frm_err_o,
  output logic               err_long_o
);

  // state | meaning
  // IDLE  | no grant; waiting for a channel valid
  // FEED  | granted channel passed through to the downscaler
  // PAD   | channel ended early; zero pixels fill the frame up to TOTAL
  // FLUSH | frame count reached; surplus channel pixels discarded until its last
  // DRAIN | waiting for the downscaler output-last handshake

  localparam int TOTAL = COL_NUM * ROW_NUM;
  localparam int CNT_W = $clog2(TOTAL);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(TOTAL - 1);

  typedef enum logic [2:0] {IDLE, FEED, PAD, FLUSH, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rr_q, rr_d;
  logic               fwd_q, fwd_d;
  logic               out_done_q, out_done_d;
  logic               frm_err_q, err_long_q;
  logic               err_d, long_d;

  logic               g_vld, g_last, g_rdy;
  logic [I_PXL_W-1:0] g_data;
  logic               at_end, out_hs;

  assign g_vld  = fwd_q ? ch1_pxl_vld_i  : ch0_pxl_vld_i;
  assign g_last = fwd_q ? ch1_pxl_last_i : ch0_pxl_last_i;
  assign g_data = fwd_q ? ch1_pxl_data_i : ch0_pxl_data_i;
  assign at_end = (cnt_q == CNT_END);
  assign out_hs = dsc_out_vld_i & dsc_out_rdy_i & dsc_out_last_i;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rr_d           = rr_q;
    fwd_d          = fwd_q;
    out_done_d     = out_done_q;
    err_d          = 1'b0;
    long_d         = 1'b0;
    g_rdy          = 1'b0;
    dsc_pxl_vld_o  = 1'b0;
    dsc_pxl_last_o = 1'b0;
    dsc_pxl_data_o = '0;
    case (state_q)
      IDLE: begin
        if (ch0_pxl_vld_i | ch1_pxl_vld_i) begin
          fwd_d      = (ch0_pxl_vld_i & ch1_pxl_vld_i) ? rr_q : ch1_pxl_vld_i;
          cnt_d      = '0;
          out_done_d = 1'b0;
          state_d    = FEED;
        end
      end
      FEED: begin
        dsc_pxl_vld_o  = g_vld;
        dsc_pxl_data_o = g_data;
        dsc_pxl_last_o = at_end;
        g_rdy          = dsc_pxl_rdy_i;
        if (g_vld & dsc_pxl_rdy_i) begin
          if (!at_end) cnt_d = cnt_q + 1'b1;
          if (at_end & g_last) begin
            state_d = DRAIN;
          end else if (g_last) begin
            err_d   = 1'b1;
            state_d = PAD;
          end else if (at_end) begin
            err_d   = 1'b1;
            long_d  = 1'b1;
            state_d = FLUSH;
          end
        end
      end
      PAD: begin
        dsc_pxl_vld_o  = 1'b1;
        dsc_pxl_last_o = at_end;
        if (dsc_pxl_rdy_i) begin
          if (at_end) state_d = DRAIN;
          else        cnt_d   = cnt_q + 1'b1;
        end
      end
      FLUSH: begin
        g_rdy = 1'b1;
        if (out_hs) out_done_d = 1'b1;
        // an output last seen here or earlier in FLUSH means nothing is left to drain
        if (g_vld & g_last) begin
          if (out_done_q | out_hs) begin
            state_d = IDLE;
            rr_d    = ~fwd_q;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_hs) begin
          state_d = IDLE;
          rr_d    = ~fwd_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rr_q       <= 1'b0;
      fwd_q      <= 1'b0;
      out_done_q <= 1'b0;
      frm_err_q  <= 1'b0;
      err_long_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      fwd_q      <= fwd_d;
      out_done_q <= out_done_d;
      frm_err_q  <= err_d;
      err_long_q <= err_d & long_d;
    end
  end

  assign ch0_pxl_rdy_o = g_rdy & ~fwd_q;
  assign ch1_pxl_rdy_o = g_rdy &  fwd_q;
  assign fwd_ch_id_o   = fwd_q;
  assign busy_o        = (state_q != IDLE);
  assign frm_err_o     = frm_err_q;
  assign err_long_o    = err_long_q;

endmodule

// File: tb/tb_drc_dsc_frm_arbiter.sv
// Bench for drc_dsc_frm_arbiter with a 4x2 frame: cycle vector table plus
// source/sink driven sequences for contention, long frame, backpressure and reset.
module tb_drc_dsc_frm_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] ch0_pxl_data_i, ch1_pxl_data_i;
  logic       ch0_pxl_last_i, ch1_pxl_last_i;
  logic       ch0_pxl_vld_i, ch1_pxl_vld_i;
  logic       ch0_pxl_rdy_o, ch1_pxl_rdy_o;
  logic [7:0] dsc_pxl_data_o;
  logic       dsc_pxl_last_o, dsc_pxl_vld_o, dsc_pxl_rdy_i;
  logic       dsc_out_last_i, dsc_out_vld_i, dsc_out_rdy_i;
  logic       fwd_ch_id_o, busy_o, frm_err_o, err_long_o;

  drc_dsc_frm_arbiter #(.I_PXL_W(8), .COL_NUM(4), .ROW_NUM(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .ch0_pxl_data_i (ch0_pxl_data_i),
    .ch0_pxl_last_i (ch0_pxl_last_i),
    .ch0_pxl_vld_i  (ch0_pxl_vld_i),
    .ch0_pxl_rdy_o  (ch0_pxl_rdy_o),
    .ch1_pxl_data_i (ch1_pxl_data_i),
    .ch1_pxl_last_i (ch1_pxl_last_i),
    .ch1_pxl_vld_i  (ch1_pxl_vld_i),
    .ch1_pxl_rdy_o  (ch1_pxl_rdy_o),
    .dsc_pxl_data_o (dsc_pxl_data_o),
    .dsc_pxl_last_o (dsc_pxl_last_o),
    .dsc_pxl_vld_o  (dsc_pxl_vld_o),
    .dsc_pxl_rdy_i  (dsc_pxl_rdy_i),
    .dsc_out_last_i (dsc_out_last_i),
    .dsc_out_vld_i  (dsc_out_vld_i),
    .dsc_out_rdy_i  (dsc_out_rdy_i),
    .fwd_ch_id_o    (fwd_ch_id_o),
    .busy_o         (busy_o),
    .frm_err_o      (frm_err_o),
    .err_long_o     (err_long_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       c0v, c0l;
    logic [7:0] c0d;
    logic       c1v, c1l;
    logic [7:0] c1d;
    logic       drdy, ov, orv, ol;
    logic       e0r, e1r, edv, edl;
    logic [7:0] edd;
    logic       efwd, ebusy, eerr, elong;
  } vec_t;

  vec_t vq[$];

  task automatic tv(input int rst_v, input int c0v, input int c0l, input int c0d,
                    input int c1v, input int c1l, input int c1d,
                    input int drdy, input int ov, input int orv, input int ol,
                    input int e0r, input int e1r, input int edv, input int edl, input int edd,
                    input int efwd, input int ebusy, input int eerr, input int elong);
    vec_t v;
    v.rst = 1'(rst_v);  v.c0v = 1'(c0v);  v.c0l = 1'(c0l);  v.c0d = 8'(c0d);
    v.c1v = 1'(c1v);    v.c1l = 1'(c1l);  v.c1d = 8'(c1d);
    v.drdy = 1'(drdy);  v.ov = 1'(ov);    v.orv = 1'(orv);  v.ol = 1'(ol);
    v.e0r = 1'(e0r);    v.e1r = 1'(e1r);  v.edv = 1'(edv);  v.edl = 1'(edl);
    v.edd = 8'(edd);    v.efwd = 1'(efwd); v.ebusy = 1'(ebusy);
    v.eerr = 1'(eerr);  v.elong = 1'(elong);
    vq.push_back(v);
  endtask

  // source/sink model state for the sequences
  int   len[2];
  bit   en[2];
  int   idx[2];
  int   k, frames, pend, pend_delay, stall, errs, errs_long;
  bit   toggle;
  bit   src_done[2];
  bit   dsc_last_hs, out_hs;
  logic s_busy, s_fwd, s_err, s_long, s_dv, s_r0, s_r1;
  logic [7:0] s_dd;

  task automatic do_reset();
    rst = 1'b1;
    ch0_pxl_vld_i = 1'b0; ch0_pxl_last_i = 1'b0; ch0_pxl_data_i = 8'h00;
    ch1_pxl_vld_i = 1'b0; ch1_pxl_last_i = 1'b0; ch1_pxl_data_i = 8'h00;
    dsc_pxl_rdy_i = 1'b1; dsc_out_vld_i = 1'b0; dsc_out_rdy_i = 1'b1; dsc_out_last_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idx[0] = 0; idx[1] = 0; en[0] = 0; en[1] = 0; len[0] = 8; len[1] = 8;
    k = 0; frames = 0; pend = 0; pend_delay = 2; stall = 0;
    errs = 0; errs_long = 0; toggle = 0; out_hs = 0; dsc_last_hs = 0;
    src_done[0] = 0; src_done[1] = 0;
  endtask

  task automatic step();
    logic [7:0] exp_d;
    logic g;
    ch0_pxl_vld_i  = en[0];
    ch0_pxl_last_i = en[0] && (idx[0] == len[0] - 1);
    ch0_pxl_data_i = en[0] ? 8'(idx[0]) : 8'h00;
    ch1_pxl_vld_i  = en[1];
    ch1_pxl_last_i = en[1] && (idx[1] == len[1] - 1);
    ch1_pxl_data_i = en[1] ? (8'h80 | 8'(idx[1])) : 8'h00;
    dsc_pxl_rdy_i  = toggle ? ~dsc_pxl_rdy_i : 1'b1;
    dsc_out_vld_i  = (pend == 1);
    dsc_out_last_i = (pend == 1);
    dsc_out_rdy_i  = (stall == 0);
    #1;
    s_busy = busy_o; s_fwd = fwd_ch_id_o; s_err = frm_err_o; s_long = err_long_o;
    s_dv = dsc_pxl_vld_o; s_r0 = ch0_pxl_rdy_o; s_r1 = ch1_pxl_rdy_o; s_dd = dsc_pxl_data_o;
    g = fwd_ch_id_o;
    src_done[0] = 0; src_done[1] = 0; dsc_last_hs = 0;
    if (!busy_o) k = 0;
    else chk1("hold_off_rdy", g ? ch0_pxl_rdy_o : ch1_pxl_rdy_o, 1'b0);
    if (s_err) begin
      errs++;
      if (s_long) errs_long++;
    end
    out_hs = (pend == 1) && (stall == 0);
    if (out_hs) pend = 0;
    else if (pend > 1) pend--;
    if (stall > 0) stall--;
    if (dsc_pxl_vld_o && dsc_pxl_rdy_i) begin
      if (k < len[g]) exp_d = g ? (8'h80 | 8'(k)) : 8'(k);
      else            exp_d = 8'h00;
      chk8("dsc_data", dsc_pxl_data_o, exp_d);
      chk1("dsc_last", dsc_pxl_last_o, (k == 7));
      k++;
      if (dsc_pxl_last_o) begin
        frames++;
        pend = pend_delay;
        dsc_last_hs = 1;
        chk_int("frame_len", k, 8);
      end
    end
    if (ch0_pxl_vld_i && ch0_pxl_rdy_o) begin
      if (ch0_pxl_last_i) begin idx[0] = 0; src_done[0] = 1; end
      else idx[0]++;
    end
    if (ch1_pxl_vld_i && ch1_pxl_rdy_o) begin
      if (ch1_pxl_last_i) begin idx[1] = 0; src_done[1] = 1; end
      else idx[1]++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, dcnt;
    bit waiting;
    logic fw[3];

    // vector table: single ch0 frame, then short ch1 frame won by round-robin
    tv(1, 1,0,16'h10, 0,0,0, 1, 0,0,0,  0,0,0,0,0, 0,0,0,0);
    tv(0, 1,0,16'h10, 0,0,0, 1, 0,0,0,  0,0,0,0,0, 0,0,0,0);
    for (int i = 0; i < 8; i++)
      tv(0, 1,(i==7)?1:0,16+i, 0,0,0, 1, 0,0,0,  1,0,1,(i==7)?1:0,16+i, 0,1,0,0);
    tv(0, 0,0,0, 0,0,0, 1, 1,1,0,  0,0,0,0,0, 0,1,0,0);
    tv(0, 0,0,0, 0,0,0, 1, 1,1,1,  0,0,0,0,0, 0,1,0,0);
    tv(0, 0,0,0, 0,0,0, 1, 0,0,0,  0,0,0,0,0, 0,0,0,0);
    tv(0, 1,0,8'h55, 1,0,8'hA0, 1, 0,0,0,  0,0,0,0,0, 0,0,0,0);
    for (int i = 0; i < 5; i++)
      tv(0, 1,0,8'h55, 1,(i==4)?1:0,160+i, 1, 0,0,0,  0,1,1,0,160+i, 1,1,0,0);
    tv(0, 0,0,0, 1,0,8'hEE, 1, 0,0,0,  0,0,1,0,0, 1,1,1,0);
    tv(0, 0,0,0, 1,0,8'hEE, 1, 0,0,0,  0,0,1,0,0, 1,1,0,0);
    tv(0, 0,0,0, 1,0,8'hEE, 1, 0,0,0,  0,0,1,1,0, 1,1,0,0);
    tv(0, 0,0,0, 1,0,8'hEE, 1, 1,1,1,  0,0,0,0,0, 1,1,0,0);
    tv(0, 0,0,0, 0,0,0, 1, 0,0,0,  0,0,0,0,0, 1,0,0,0);

    rst = 1'b1;
    ch0_pxl_vld_i = 1'b0; ch0_pxl_last_i = 1'b0; ch0_pxl_data_i = 8'h00;
    ch1_pxl_vld_i = 1'b0; ch1_pxl_last_i = 1'b0; ch1_pxl_data_i = 8'h00;
    dsc_pxl_rdy_i = 1'b1; dsc_out_vld_i = 1'b0; dsc_out_rdy_i = 1'b1; dsc_out_last_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    foreach (vq[r]) begin
      rst = vq[r].rst;
      ch0_pxl_vld_i = vq[r].c0v; ch0_pxl_last_i = vq[r].c0l; ch0_pxl_data_i = vq[r].c0d;
      ch1_pxl_vld_i = vq[r].c1v; ch1_pxl_last_i = vq[r].c1l; ch1_pxl_data_i = vq[r].c1d;
      dsc_pxl_rdy_i = vq[r].drdy;
      dsc_out_vld_i = vq[r].ov; dsc_out_rdy_i = vq[r].orv; dsc_out_last_i = vq[r].ol;
      #1;
      chk1($sformatf("v%0d_ch0_rdy", r), ch0_pxl_rdy_o, vq[r].e0r);
      chk1($sformatf("v%0d_ch1_rdy", r), ch1_pxl_rdy_o, vq[r].e1r);
      chk1($sformatf("v%0d_dsc_vld", r), dsc_pxl_vld_o, vq[r].edv);
      chk1($sformatf("v%0d_dsc_last", r), dsc_pxl_last_o, vq[r].edl);
      chk8($sformatf("v%0d_dsc_data", r), dsc_pxl_data_o, vq[r].edd);
      chk1($sformatf("v%0d_fwd", r), fwd_ch_id_o, vq[r].efwd);
      chk1($sformatf("v%0d_busy", r), busy_o, vq[r].ebusy);
      chk1($sformatf("v%0d_frm_err", r), frm_err_o, vq[r].eerr);
      chk1($sformatf("v%0d_err_long", r), err_long_o, vq[r].elong);
      @(posedge clk); #1;
    end

    // contention: both channels valid from reset -> ch0, ch1, ch0
    do_reset();
    en[0] = 1; en[1] = 1;
    fw[0] = 1'bx; fw[1] = 1'bx; fw[2] = 1'bx;
    n = 0;
    while (frames < 3 && n < 300) begin
      step();
      if (dsc_last_hs) fw[frames-1] = s_fwd;
      n++;
    end
    chk_int("contention_frames", frames, 3);
    chk1("contention_fwd0", fw[0], 1'b0);
    chk1("contention_fwd1", fw[1], 1'b1);
    chk1("contention_fwd2", fw[2], 1'b0);
    chk_int("contention_errs", errs, 0);

    // long frame: 11 pixels, output last arrives during FLUSH
    do_reset();
    en[0] = 1; len[0] = 11; pend_delay = 1;
    n = 0;
    while (!src_done[0] && n < 100) begin
      step();
      n++;
    end
    chk1("long_src_done", src_done[0], 1'b1);
    en[0] = 0;
    step();
    chk1("long_flush_to_idle", s_busy, 1'b0);
    chk_int("long_frames", frames, 1);
    chk_int("long_err_pulses", errs, 1);
    chk_int("long_err_long", errs_long, 1);

    // backpressure: toggling input ready, output ready low for 20 cycles
    do_reset();
    en[1] = 1; toggle = 1; pend_delay = 1;
    n = 0; dcnt = 0; waiting = 0;
    while (!out_hs && n < 300) begin
      step();
      if (src_done[1]) en[1] = 0;
      if (waiting && !out_hs) begin
        chk1("drain_hold_busy", s_busy, 1'b1);
        dcnt++;
      end
      if (dsc_last_hs) begin
        waiting = 1;
        stall = 20;
      end
      n++;
    end
    chk1("bp_out_hs", out_hs, 1'b1);
    toggle = 0;
    step();
    chk1("bp_idle_after_hs", s_busy, 1'b0);
    chk_int("bp_drain_cycles", dcnt, 20);
    chk_int("bp_frames", frames, 1);
    chk_int("bp_errs", errs, 0);

    // mid-frame reset after pixel 3, then a clean frame
    do_reset();
    en[0] = 1;
    n = 0;
    while (idx[0] != 3 && n < 50) begin
      step();
      n++;
    end
    chk_int("mid_reset_reached", idx[0], 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idx[0] = 0;
    step();
    chk1("mid_reset_busy", s_busy, 1'b0);
    chk1("mid_reset_dsc_vld", s_dv, 1'b0);
    chk1("mid_reset_rdy0", s_r0, 1'b0);
    chk1("mid_reset_rdy1", s_r1, 1'b0);
    chk1("mid_reset_fwd", s_fwd, 1'b0);
    chk1("mid_reset_err", s_err, 1'b0);
    chk8("mid_reset_data", s_dd, 8'h00);
    frames = 0; errs = 0; pend_delay = 2;
    n = 0;
    while (!out_hs && n < 100) begin
      step();
      if (src_done[0]) en[0] = 0;
      n++;
    end
    chk_int("mid_reset_clean_frames", frames, 1);
    chk_int("mid_reset_clean_errs", errs, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
